// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch prefetch queue.
package mips_fetch_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] instr;
    } pfq_entry_t;

endpackage

// File: rtl/pfq_fifo.sv
// Synchronous FIFO with flush; power-of-two DEPTH so the pointers wrap for free.
// rst_n is a synchronous active-high reset.
module pfq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);

    localparam int             AW   = $clog2(DEPTH);
    localparam int             CW   = AW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates validity, so the contents never matter when empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers in-order responses, drains stale ones after a redirect.
// Define FETCH_PFQ_BYPASS_EN to forward a response straight to decode when the queue is empty. rst_n is synchronous active-high.
module fetch_prefetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc_plus_4,
    input  logic            dec_ready
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] OUT_LIMIT = CW'(MAX_OUT);
    localparam logic [CW:0]   OCC_LIMIT = (CW+1)'(DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_fetch_addr;
    logic [XLEN-1:0] w_fetch_addr_nxt;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   w_inflight_nxt;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   w_drop_cnt_nxt;

    logic [CW-1:0]   w_fifo_count;
    pfq_entry_t      w_fifo_head;
    pfq_entry_t      w_push_entry;
    logic            w_fifo_valid;
    logic [CW:0]     w_occupancy;
    logic [XLEN-1:0] w_rsp_pc;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_bypass_take;

    // Space is reserved at issue time: queued entries plus outstanding requests never exceed DEPTH.
    assign w_occupancy    = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign imem_req_valid = !rst_n && (r_state == FETCH)
                            && (r_inflight < OUT_LIMIT) && (w_occupancy < OCC_LIMIT);
    assign imem_req_addr  = r_fetch_addr;
    assign w_issue        = imem_req_valid && imem_req_ready;

    // Responses are in order, so the oldest outstanding request sits inflight words behind the fetch address.
    assign w_rsp_pc               = r_fetch_addr - XLEN'(r_inflight) * PC_STEP;
    assign w_push_entry.pc_plus_4 = w_rsp_pc + PC_STEP;
    assign w_push_entry.instr     = imem_rsp_data;

    assign w_inflight_nxt = r_inflight + CW'(w_issue) - CW'(imem_rsp_valid);

    assign w_push = (r_state == FETCH) && imem_rsp_valid && !redirect_valid && !w_bypass_take;
    assign w_pop  = (w_fifo_count != '0) && dec_ready && !redirect_valid;

    pfq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pfq_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_fifo_count),
        .o_head      (w_fifo_head)
    );

    assign w_fifo_valid = !rst_n && (w_fifo_count != '0);

`ifdef FETCH_PFQ_BYPASS_EN
    logic w_bypass;

    assign w_bypass      = !rst_n && (r_state == FETCH) && (w_fifo_count == '0) && imem_rsp_valid;
    assign w_bypass_take = w_bypass && dec_ready && !redirect_valid;

    always_comb begin
        dec_valid     = 1'b0;
        dec_instr     = NOP_INSTR;
        dec_pc_plus_4 = '0;
        if (w_bypass) begin
            dec_valid     = 1'b1;
            dec_instr     = imem_rsp_data;
            dec_pc_plus_4 = w_push_entry.pc_plus_4;
        end else if (w_fifo_valid) begin
            dec_valid     = 1'b1;
            dec_instr     = w_fifo_head.instr;
            dec_pc_plus_4 = w_fifo_head.pc_plus_4;
        end
    end
`else
    assign w_bypass_take = 1'b0;

    always_comb begin
        dec_valid     = w_fifo_valid;
        dec_instr     = w_fifo_valid ? w_fifo_head.instr : NOP_INSTR;
        dec_pc_plus_4 = w_fifo_valid ? w_fifo_head.pc_plus_4 : '0;
    end
`endif

    // NOTE: every next-state value gets a default first, so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_addr_nxt = r_fetch_addr;
        w_drop_cnt_nxt   = r_drop_cnt;
        case (r_state)
            FETCH: begin
                if (redirect_valid) begin
                    w_fetch_addr_nxt = redirect_pc;
                    if (w_inflight_nxt != '0) begin
                        w_state_nxt    = DRAIN;
                        w_drop_cnt_nxt = w_inflight_nxt;
                    end
                end else if (w_issue) begin
                    w_fetch_addr_nxt = r_fetch_addr + PC_STEP;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) w_drop_cnt_nxt = r_drop_cnt - 1'b1;
                if (redirect_valid) begin
                    w_fetch_addr_nxt = redirect_pc;
                    w_drop_cnt_nxt   = w_inflight_nxt;
                end
                if (w_drop_cnt_nxt == '0) w_state_nxt = FETCH;
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= FETCH;
            r_fetch_addr <= RESET_PC;
            r_inflight   <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_addr <= w_fetch_addr_nxt;
            r_inflight   <= w_inflight_nxt;
            r_drop_cnt   <= w_drop_cnt_nxt;
        end
    end

endmodule
